// File: rtl/seq_alu_pkg.sv
// Shared op codes, FSM state type and helpers for the sequential ALU.
package seq_alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // True for the ops that run on the iterative datapath.
    function automatic logic is_iter_op(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Iterative shift-add multiplier / restoring divider sharing one adder.
// hi/lo hold {partial product, multiplier} or {remainder, quotient}.
module seq_alu_iter
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_nxt,
    output logic [WIDTH-1:0] lo_nxt
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] opnd;
    logic             div_q;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   op_x;
    logic [WIDTH:0]   op_y;
    logic [WIDTH+1:0] add;

    assign done = busy && (count == CW'(WIDTH - 1));

    // One iteration: multiply adds the multiplicand and shifts right; divide
    // shifts left and subtracts the divisor, restoring on borrow. The divide
    // subtract is the same adder fed with the inverted divisor and carry-in.
    always_comb begin
        op_x   = div_q ? {hi, lo[WIDTH-1]} : {1'b0, hi};
        op_y   = div_q ? ~{1'b0, opnd} : {1'b0, opnd};
        add    = {1'b0, op_x} + {1'b0, op_y} + {{(WIDTH+1){1'b0}}, div_q};
        hi_nxt = {1'b0, hi[WIDTH-1:1]};
        lo_nxt = {hi[0], lo[WIDTH-1:1]};
        if (div_q) begin
            if (add[WIDTH+1]) begin
                hi_nxt = add[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = op_x[WIDTH-1:0];
                lo_nxt = {lo[WIDTH-2:0], 1'b0};
            end
        end else if (lo[0]) begin
            hi_nxt = add[WIDTH:1];
            lo_nxt = {add[0], lo[WIDTH-1:1]};
        end
    end

    // Operand load on start, then WIDTH iterations with the cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi    <= '0;
            lo    <= '0;
            opnd  <= '0;
            div_q <= 1'b0;
            busy  <= 1'b0;
            count <= '0;
        end else if (start) begin
            hi    <= '0;
            lo    <= is_div ? a : b;
            opnd  <= is_div ? b : a;
            div_q <= is_div;
            busy  <= 1'b1;
            count <= '0;
        end else if (busy) begin
            hi    <= hi_nxt;
            lo    <= lo_nxt;
            count <= count + 1'b1;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked ALU: single-cycle logic/arith ops plus iterative MULU/DIVU,
// with registered results held until the consumer accepts them.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALU_operation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic             Co,
    output logic             zero,
    output logic             overflow
);

    localparam int SHW = $clog2(WIDTH);

    state_t state_q, state_d;

    logic             accept;
    logic             iter_req;
    logic             iter_busy;
    logic             iter_done;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;
    logic             is_div_q;
    logic             div_zero_q;

    logic [WIDTH-1:0] b_add;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH-1:0] core_res;
    logic             core_co;
    logic             core_ovf;
    logic             core_zero;

    assign accept   = in_valid && in_ready;
    assign iter_req = is_iter_op(ALU_operation);

    seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && iter_req),
        .is_div (ALU_operation == OP_DIVU),
        .a      (A),
        .b      (B),
        .busy   (iter_busy),
        .done   (iter_done),
        .hi_nxt (iter_hi),
        .lo_nxt (iter_lo)
    );

    // Single-cycle core evaluated on the live inputs; its result is captured
    // into the output registers on the accept edge.
    always_comb begin
        core_res = '0;
        core_co  = 1'b0;
        core_ovf = 1'b0;
        b_add    = (ALU_operation == OP_SUB) ? ~B : B;
        add_ext  = {1'b0, A} + {1'b0, b_add} + {{WIDTH{1'b0}}, (ALU_operation == OP_SUB)};
        case (ALU_operation)
            OP_AND: core_res = A & B;
            OP_OR:  core_res = A | B;
            OP_XOR: core_res = A ^ B;
            OP_NOR: core_res = ~(A | B);
            OP_SRL: core_res = A >> B[SHW-1:0];
            OP_SLT: core_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_ADD, OP_SUB: begin
                core_res = add_ext[WIDTH-1:0];
                core_co  = add_ext[WIDTH];
                core_ovf = (A[WIDTH-1] == b_add[WIDTH-1]) &&
                           (add_ext[WIDTH-1] != A[WIDTH-1]);
            end
            default: core_res = '0;
        endcase
        core_zero = (core_res == '0);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = rst_n;
                if (accept) begin
                    state_d = iter_req ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (iter_done) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Op attributes latched at accept for the iterative result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_div_q   <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (accept) begin
            is_div_q   <= (ALU_operation == OP_DIVU);
            div_zero_q <= (B == '0);
        end
    end

    // Output registers: loaded at accept for single-cycle ops, on the last
    // iteration for MULU/DIVU, otherwise held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res      <= '0;
            res_hi   <= '0;
            Co       <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept && !iter_req) begin
            res      <= core_res;
            res_hi   <= '0;
            Co       <= core_co;
            zero     <= core_zero;
            overflow <= core_ovf;
        end else if (iter_busy && iter_done) begin
            res      <= iter_lo;
            res_hi   <= iter_hi;
            Co       <= 1'b0;
            zero     <= is_div_q ? (iter_lo == '0) : ({iter_hi, iter_lo} == '0);
            overflow <= is_div_q && div_zero_q;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed vector table, hand-written
// backpressure and reset sequences, and randomized ops against a model.
module tb_seq_alu;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    ALU_operation;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  res;
    logic [W-1:0]  res_hi;
    logic          Co;
    logic          zero;
    logic          overflow;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .ALU_operation (ALU_operation),
        .A             (A),
        .B             (B),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .res           (res),
        .res_hi        (res_hi),
        .Co            (Co),
        .zero          (zero),
        .overflow      (overflow)
    );

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] r;
        logic [W-1:0] rh;
        logic         co;
        logic         z;
        logic         ov;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference model from the arithmetic definition of each op.
    task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] r, output logic [W-1:0] rh,
                         output logic co, output logic z, output logic ov);
        longint s;
        longint lim_hi;
        longint lim_lo;
        logic [63:0] p;
        lim_hi = 64'sd2147483647;
        lim_lo = -64'sd2147483648;
        r = '0; rh = '0; co = 1'b0; ov = 1'b0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd3: r = a ^ b;
            4'd4: r = ~(a | b);
            4'd5: r = a >> b[4:0];
            4'd7: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd2: begin
                p  = {32'b0, a} + {32'b0, b};
                r  = p[31:0];
                co = p[32];
                s  = longint'($signed(a)) + longint'($signed(b));
                ov = (s > lim_hi) || (s < lim_lo);
            end
            4'd6: begin
                r  = a - b;
                co = (a >= b);
                s  = longint'($signed(a)) - longint'($signed(b));
                ov = (s > lim_hi) || (s < lim_lo);
            end
            4'd8: begin
                p  = {32'b0, a} * {32'b0, b};
                r  = p[31:0];
                rh = p[63:32];
            end
            4'd9: begin
                if (b == 0) begin
                    r = '1; rh = a; ov = 1'b1;
                end else begin
                    r = a / b; rh = a % b;
                end
            end
            default: ;
        endcase
        z = (op == 4'd8) ? ({rh, r} == 64'd0) : (r == 32'd0);
    endtask

    // Issue one op, wait for the result, optionally stall the consumer for
    // `hold` cycles while scrambling the inputs, then accept the result.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold,
                          output logic [W-1:0] r, output logic [W-1:0] rh,
                          output logic co, output logic z, output logic ov, output int lat);
        int          wc;
        logic        rdy_bad;
        logic        hold_bad;
        wc = 0; rdy_bad = 1'b0; hold_bad = 1'b0;
        @(negedge clk);
        ALU_operation = op; A = a; B = b; in_valid = 1'b1;
        while (!in_ready && wc < 100) begin
            @(negedge clk);
            wc++;
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ALU_operation = 4'($urandom); A = $urandom; B = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && in_ready) rdy_bad = 1'b1;
        end while (!out_valid && lat < 200);
        chk("in_ready_low_while_busy", 64'(rdy_bad), 64'd0);
        r = res; rh = res_hi; co = Co; z = zero; ov = overflow;
        if (hold > 0) begin
            repeat (hold) begin
                ALU_operation = 4'($urandom); A = $urandom; B = $urandom;
                @(negedge clk);
                if (!out_valid || in_ready || res !== r || res_hi !== rh ||
                    Co !== co || zero !== z || overflow !== ov) hold_bad = 1'b1;
            end
            chk("held_under_backpressure", 64'(hold_bad), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("idle_after_handshake", {62'd0, in_ready, out_valid}, 64'b10);
    endtask

    task automatic apply(input string name, input vec_t v, input int hold);
        logic [W-1:0] r, rh;
        logic         co, z, ov;
        int           lat;
        int           exp_lat;
        run_op(v.op, v.a, v.b, hold, r, rh, co, z, ov, lat);
        exp_lat = (v.op == 4'd8 || v.op == 4'd9) ? W + 1 : 1;
        chk({name, "_res"},     64'(r),  64'(v.r));
        chk({name, "_res_hi"},  64'(rh), 64'(v.rh));
        chk({name, "_flags"},   {61'd0, co, z, ov}, {61'd0, v.co, v.z, v.ov});
        chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    endtask

    initial begin
        vec_t v;
        logic [3:0] op;
        logic [W-1:0] ra, rb;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ALU_operation = '0; A = '0; B = '0;
        #12;
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_outputs", {res_hi, res}, 64'd0);
        chk("reset_valid_flags", {60'd0, out_valid, Co, zero, overflow}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_reset", 64'(in_ready), 64'd1);

        //            op     A             B             res           res_hi        co    z     ov
        vecs.push_back('{4'h2, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h6, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h4B4B4B4B, 32'h0,        1'b1, 1'b0, 1'b1});
        vecs.push_back('{4'h7, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000001, 32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h4, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000, 32'h0,        1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'h0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000, 32'h0,        1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'h1, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h3, 32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h5, 32'h80000000, 32'h0000001F, 32'h00000001, 32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h5, 32'h80000000, 32'h00000021, 32'h40000000, 32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h2, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0,        1'b0, 1'b0, 1'b1});
        vecs.push_back('{4'h2, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0,        1'b1, 1'b1, 1'b0});
        vecs.push_back('{4'h6, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h8, 32'h00010000, 32'h00010000, 32'h00000000, 32'h00000001, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h8, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'h9, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 1'b0});
        vecs.push_back('{4'h9, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b0, 1'b1});
        vecs.push_back('{4'h9, 32'd5,        32'd10,       32'd0,        32'd5,        1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'hA, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 32'h0,        1'b0, 1'b1, 1'b0});
        vecs.push_back('{4'hF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h0,        1'b0, 1'b1, 1'b0});

        foreach (vecs[i]) apply($sformatf("vec%0d", i), vecs[i], 0);

        // Backpressure: ADD held for 5 cycles with inputs scrambled.
        apply("bp_add", '{4'h2, 32'h01010101, 32'h02020202, 32'h03030303, 32'h0, 1'b0, 1'b0, 1'b0}, 5);
        // Backpressure on an iterative result.
        apply("bp_divu", '{4'h9, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b0, 1'b0, 1'b0}, 3);

        // Randomized ops against the model.
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            v.op = op; v.a = ra; v.b = rb;
            model(op, ra, rb, v.r, v.rh, v.co, v.z, v.ov);
            apply($sformatf("rnd%0d_op%0h", i, op), v, int'($urandom_range(0, 2)));
        end

        // Reset in the middle of a MULU, with non-zero results registered.
        apply("pre_rst_sub", '{4'h6, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h4B4B4B4B, 32'h0, 1'b1, 1'b0, 1'b1}, 0);
        @(negedge clk);
        ALU_operation = 4'h8; A = 32'hFFFFFFFF; B = 32'h00000003; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {res_hi, res}, 64'd0);
        chk("midrst_valid_flags", {60'd0, out_valid, Co, zero, overflow}, 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        apply("post_rst_add", '{4'h2, 32'h01234567, 32'h76543210, 32'h77777777, 32'h0, 1'b0, 1'b0, 1'b0}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, handshaked successor to the 32-bit combinational ALU.
- Keeps the 3-bit single-cycle operation set and the co/zero/overflow flags.
- Adds registered outputs, valid/ready flow control, a high result word, and two iterative ops: unsigned multiply (shift-add) and unsigned divide (restoring).
- Sits between the register file read stage and writeback; one operation in flight at a time.

Parameters:
WIDTH, 32, operand/result width; power of two, 8..64
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation request
in_ready  output  1  block can accept a request
ALU_operation  input  4  op code; bit 3 selects extended ops
A  input  WIDTH  operand A
B  input  WIDTH  operand B
out_valid  output  1  result registers valid
out_ready  input  1  consumer accepts result
res  output  WIDTH  result low word / quotient
res_hi  output  WIDTH  product high word / remainder; 0 for single-cycle ops
Co  output  1  carry out (ADD/SUB only, else 0)
zero  output  1  result equals zero
overflow  output  1  signed overflow (ADD/SUB) or divide-by-zero (DIVU)

Behaviour:
- Reset (async, rst_n=0): state IDLE. in_ready=0 while rst_n low. out_valid, res, res_hi, Co, zero, overflow=0. Iteration counter and accumulators cleared. Applies mid-operation; the in-flight op is discarded.
- FSM states: IDLE, BUSY, DONE.
- IDLE: in_ready=1. in_valid&in_ready latches op, A, B.
  - Single-cycle op -> DONE.
  - MULU/DIVU -> BUSY, count=0.
- BUSY: in_ready=0. One iteration per cycle for WIDTH cycles. When count==WIDTH-1, results are written and state -> DONE.
- DONE: out_valid=1; outputs held stable until out_ready. out_valid&out_ready -> IDLE. No accept in the same cycle; in_ready rises the following cycle.
- Latency, accept edge to out_valid: 1 cycle for single-cycle ops; WIDTH+1 cycles for MULU/DIVU.
- Throughput: single-cycle ops 1 per 2 cycles; iterative ops 1 per WIDTH+2 cycles.
- Op codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0100 NOR
  - 0101 SRL: A >> B[SHW-1:0], logical
  - 0110 SUB: A + ~B + 1
  - 0111 SLT: signed, res=1 if A<B else 0
  - 1000 MULU: {res_hi,res} = A*B unsigned
  - 1001 DIVU: res = A/B, res_hi = A%B
  - 1010..1111 illegal: 1-cycle, res=0, res_hi=0, zero=1, other flags 0
- Co: carry out of the WIDTH-bit adder for ADD and SUB. For SUB, Co=1 means no borrow (A>=B unsigned).
- overflow:
  - ADD/SUB: operand sign bits (after B inversion for SUB) agree and result sign differs.
  - DIVU: overflow=1 when B==0. Result is then res = all ones, res_hi = A; the op still takes WIDTH+1 cycles.
  - All other ops: 0.
- zero:
  - MULU: {res_hi,res}==0.
  - DIVU: res==0.
  - Otherwise: res==0.
- Operands are captured at accept; input changes during BUSY/DONE have no effect.

Decomposition:
- Package seq_alu_pkg: op-code localparams (OP_AND..OP_DIVU), FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
- Sub-module seq_alu_iter: shared shift-add/restoring-subtract datapath, the WIDTH-cycle counter, and its start/done pulse.
- The top holds the single-cycle combinational core, the FSM and the output registers.

Test Plan:
- ADD, A=A5A5A5A5, B=5A5A5A5A -> res=FFFFFFFF, Co=0, overflow=0, zero=0; out_valid 1 cycle after accept.
- SUB, same operands -> res=4B4B4B4B, Co=1, overflow=1. SLT -> res=1. NOR -> res=00000000, zero=1.
- MULU, A=00010000, B=00010000 -> res_hi=00000001, res=00000000, zero=0; out_valid exactly 33 cycles after accept; in_ready=0 throughout.
- DIVU, A=100, B=7 -> res=14, res_hi=2, overflow=0. DIVU with B=0 -> res=FFFFFFFF, res_hi=A, overflow=1.
- Backpressure: ADD completes with out_ready=0 for 5 cycles -> out_valid and outputs held; in_ready=0; A/B/ALU_operation toggled meanwhile do not alter res. out_ready=1 -> IDLE next cycle.
- Reset mid-MULU: rst_n low at count=10 -> out_valid, res, res_hi and flags 0 immediately. After release, in_ready=1 and a new ADD 01234567+76543210 returns 77777777.
